conv_relu_maxpool: RTL and testbench

- Streaming stage directly downstream of the multi-filter convolution layer.
- Accepts convolution results one word per handshake, clamps each to ReLU, and performs 2x2/stride-2 max pooling per feature map.
- Emits pooled words in raster order, map by map, to the next layer's input buffer.
- Values are IEEE-754 single precision. After ReLU every operand is non-negative, so max is an unsigned integer compare on the raw bits; no FP unit is needed.

---
 rtl/conv_relu_maxpool.sv | 175 +++++++++++++++++
 tb/tb_conv_relu_maxpool.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_relu_maxpool.sv
// ReLU clamp + 2x2/stride-2 max pool over a stream of conv feature maps.
// Define POOL_ARGMAX_EN to add out_argmax (winning position in each window).
module conv_relu_maxpool #(
    parameter int DATA_WIDTH = 32,
    parameter int H          = 28,
    parameter int W          = 28,
    parameter int K          = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
`ifdef POOL_ARGMAX_EN
    output logic [1:0]            out_argmax,
`endif
    output logic                  busy,
    output logic                  done
);

    if ((H % 2) != 0 || H < 2) begin : g_bad_h
        $error("conv_relu_maxpool: H must be even");
    end
    if ((W % 2) != 0 || W < 2) begin : g_bad_w
        $error("conv_relu_maxpool: W must be even");
    end

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int MW = (K > 1) ? $clog2(K) : 1;
    localparam int LN = W / 2;
    localparam int LW = (LN > 1) ? $clog2(LN) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]            state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [MW-1:0]         map;
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] tmp;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] pick;
    logic [DATA_WIDTH-1:0] lbuf [LN];
    logic [LW-1:0]         lidx;
    logic                  in_fire;
    logic                  out_fire;
    logic                  col_end;
    logic                  row_end;
    logic                  map_end;
    logic                  last_in;
    logic                  gt;
    logic                  use_lb;

    // Sign set means negative (including -0): clamp to +0.
    assign x       = in_data[DATA_WIDTH-1] ? '0 : in_data;
    assign lidx    = LW'(col >> 1);
    assign use_lb  = row[0] && !col[0];
    assign prev    = use_lb ? lbuf[lidx] : tmp;
    assign gt      = x > prev;
    assign pick    = gt ? x : prev;

    assign in_ready = (state == S_STREAM) && !(out_valid && !out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign col_end  = col == CW'(W - 1);
    assign row_end  = row == RW'(H - 1);
    assign map_end  = map == MW'(K - 1);
    assign last_in  = col_end && row_end && map_end;
    assign busy     = (state == S_STREAM) || (state == S_DRAIN);
    assign done     = state == S_DONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            col   <= '0;
            row   <= '0;
            map   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_STREAM;
                        col   <= '0;
                        row   <= '0;
                        map   <= '0;
                    end
                end
                S_STREAM: begin
                    if (in_fire) begin
                        col <= col_end ? '0 : col + CW'(1);
                        if (col_end) begin
                            row <= row_end ? '0 : row + RW'(1);
                            if (row_end)
                                map <= map_end ? '0 : map + MW'(1);
                        end
                        if (last_in)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_fire && out_last)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmp <= '0;
            for (int i = 0; i < LN; i++)
                lbuf[i] <= '0;
        end else if (in_fire) begin
            unique case ({row[0], col[0]})
                2'b00:   tmp <= x;
                2'b01:   lbuf[lidx] <= pick;
                2'b10:   tmp <= pick;
                default: ;
            endcase
        end
    end

    // A window closes on the odd-row/odd-col element; load wins over drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (in_fire && row[0] && col[0]) begin
            out_valid <= 1'b1;
            out_data  <= pick;
            out_last  <= last_in;
        end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef POOL_ARGMAX_EN
    logic [1:0] tmp_arg;
    logic [1:0] prev_arg;
    logic [1:0] pick_arg;
    logic [1:0] lbuf_arg [LN];

    assign prev_arg = use_lb ? lbuf_arg[lidx] : tmp_arg;
    assign pick_arg = gt ? {row[0], col[0]} : prev_arg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmp_arg    <= 2'd0;
            out_argmax <= 2'd0;
            for (int i = 0; i < LN; i++)
                lbuf_arg[i] <= 2'd0;
        end else if (in_fire) begin
            unique case ({row[0], col[0]})
                2'b00:   tmp_arg <= 2'd0;
                2'b01:   lbuf_arg[lidx] <= pick_arg;
                2'b10:   tmp_arg <= pick_arg;
                default: out_argmax <= pick_arg;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_conv_relu_maxpool.sv
// Bench for conv_relu_maxpool: small 4x4x1 instance for directed cases,
// default-size instance for randomized frames against a reference model.
`timescale 1ns/1ps
module tb_conv_relu_maxpool;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] in_data = '0;

    always #5 clk = ~clk;

    logic        start_s, start_d;
    logic        ir_s, ov_s, ol_s, bz_s, dn_s;
    logic        ir_d, ov_d, ol_d, bz_d, dn_d;
    logic [31:0] od_s, od_d;
    logic        in_ready, out_valid, out_last, busy, done;
    logic [31:0] out_data;

    assign start_s   = start & ~sel;
    assign start_d   = start & sel;
    assign in_ready  = sel ? ir_d : ir_s;
    assign out_valid = sel ? ov_d : ov_s;
    assign out_last  = sel ? ol_d : ol_s;
    assign busy      = sel ? bz_d : bz_s;
    assign done      = sel ? dn_d : dn_s;
    assign out_data  = sel ? od_d : od_s;

`ifdef POOL_ARGMAX_EN
    logic [1:0] am_s, am_d, out_argmax, first_arg;
    assign out_argmax = sel ? am_d : am_s;
`endif

    conv_relu_maxpool #(.DATA_WIDTH(32), .H(4), .W(4), .K(1)) dut_s (
        .clk(clk), .reset(reset), .start(start_s),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir_s),
        .out_data(od_s), .out_valid(ov_s), .out_ready(out_ready),
        .out_last(ol_s),
`ifdef POOL_ARGMAX_EN
        .out_argmax(am_s),
`endif
        .busy(bz_s), .done(dn_s)
    );

    conv_relu_maxpool dut_d (
        .clk(clk), .reset(reset), .start(start_d),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir_d),
        .out_data(od_d), .out_valid(ov_d), .out_ready(out_ready),
        .out_last(ol_d),
`ifdef POOL_ARGMAX_EN
        .out_argmax(am_d),
`endif
        .busy(bz_d), .done(dn_d)
    );

    int          tests = 0;
    int          fails = 0;
    int          cur_h, cur_w, cur_k;
    int          n_outs, busy_cycles;
    logic [31:0] first_out;
    logic [31:0] stim [$];
    logic [31:0] exp_d [$];
    logic [1:0]  exp_a [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] int2f(input int v);
        int          e;
        logic [31:0] m;
        if (v <= 0) return 32'h0;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        m = 32'(v) << (23 - e);
        return {1'b0, 8'(e + 127), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return {1'b0, r[30:0]};
            2:       return int2f(int'($urandom_range(1, 4)));
            default: return r | 32'h8000_0000;
        endcase
    endfunction

    // Pool each window in TL,TR,BL,BR order; only a strictly larger value wins.
    function automatic void build_expected();
        logic [31:0] v [4];
        logic [31:0] w, best;
        logic [1:0]  arg;
        int          ix;
        exp_d.delete();
        exp_a.delete();
        for (int m = 0; m < cur_k; m++)
            for (int i = 0; i < cur_h / 2; i++)
                for (int j = 0; j < cur_w / 2; j++) begin
                    for (int q = 0; q < 4; q++) begin
                        ix = m * cur_h * cur_w + (2 * i + q / 2) * cur_w
                             + 2 * j + q % 2;
                        w = stim[ix];
                        v[q] = w[31] ? 32'h0 : w;
                    end
                    best = v[0];
                    arg = 2'd0;
                    for (int q = 1; q < 4; q++)
                        if (v[q] > best) begin
                            best = v[q];
                            arg = 2'(q);
                        end
                    exp_d.push_back(best);
                    exp_a.push_back(arg);
                end
    endfunction

    task automatic run_frame(input bit rnd, input int abort_at, input bit poke);
        int idx, oi, cyc, last_fire, n;
        bit ifire, ofire, got_done;
        n = stim.size();
        idx = 0; oi = 0; cyc = 0; last_fire = -100;
        ifire = 0; ofire = 0; got_done = 0;
        n_outs = 0; busy_cycles = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!got_done && cyc < 60000) begin
            if (ifire) idx++;
            if (done) begin
                got_done = 1;
                check("done_latency", cyc - last_fire, 1);
                check("outs_at_done", oi, exp_d.size());
            end else begin
                if (busy) busy_cycles++;
                if (abort_at >= 0 && idx >= abort_at) begin
                    in_valid = 1'b0;
                    reset = 1'b0;
                    #1;
                    check("abort_out_valid", out_valid, 0);
                    check("abort_out_data", out_data, 0);
                    check("abort_out_last", out_last, 0);
                    check("abort_in_ready", in_ready, 0);
                    check("abort_busy", busy, 0);
                    check("abort_done", done, 0);
                    @(posedge clk); #1;
                    reset = 1'b1;
                    @(posedge clk); #1;
                    return;
                end
                in_valid  = (idx >= n) || !rnd || ($urandom_range(0, 3) != 0);
                in_data   = (idx < n) ? stim[idx] : $urandom;
                out_ready = !rnd || ($urandom_range(0, 2) == 0);
                start     = poke && (cyc == 3 || idx >= n);
                #1;
                ifire = in_valid && in_ready;
                ofire = out_valid && out_ready;
                if (out_valid && !out_ready)
                    check("in_ready_stall", in_ready, 0);
                if (ofire) begin
                    if (oi >= exp_d.size()) begin
                        tests++;
                        fails++;
                        $error("FAIL extra_output: got %0d outputs expected %0d",
                               oi + 1, exp_d.size());
                    end else begin
                        check("out_data", out_data, exp_d[oi]);
                        check("out_last", out_last, oi == exp_d.size() - 1);
`ifdef POOL_ARGMAX_EN
                        check("out_argmax", out_argmax, exp_a[oi]);
                        if (oi == 0) first_arg = out_argmax;
`endif
                        if (oi == 0) first_out = out_data;
                    end
                    oi++;
                    n_outs++;
                    last_fire = cyc;
                end
                cyc++;
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        check("frame_done", got_done, 1);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("busy_after", busy, 0);
    endtask

    task automatic use_dut(input logic s);
        sel = s;
        if (s) begin
            cur_h = 28; cur_w = 28; cur_k = 6;
        end else begin
            cur_h = 4; cur_w = 4; cur_k = 1;
        end
    endtask

    task automatic fill_random();
        stim.delete();
        for (int i = 0; i < cur_h * cur_w * cur_k; i++)
            stim.push_back(rand_word());
    endtask

    initial begin
        use_dut(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        stim.delete();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                stim.push_back(int2f(4 * r + c + 1));
        exp_d.delete();
        exp_a.delete();
        exp_d.push_back(int2f(6));
        exp_d.push_back(int2f(8));
        exp_d.push_back(int2f(14));
        exp_d.push_back(int2f(16));
        for (int i = 0; i < 4; i++) exp_a.push_back(2'd3);
        run_frame(1'b0, -1, 1'b0);
        check("ramp_outs", n_outs, 4);
        check("ramp_busy", busy_cycles, 17);

        run_frame(1'b0, -1, 1'b1);
        check("poke_outs", n_outs, 4);
        check("poke_busy", busy_cycles, 17);

        stim.delete();
        for (int i = 0; i < 16; i++)
            stim.push_back((i % 3 == 0) ? 32'h8000_0000 :
                           (i % 3 == 1) ? 32'hBF80_0000 :
                           (32'h8000_0000 | $urandom));
        build_expected();
        run_frame(1'b1, -1, 1'b0);
        check("neg_first", first_out, 32'h0);
        check("neg_outs", n_outs, 4);

        fill_random();
        stim[0] = int2f(2);
        stim[1] = int2f(5);
        stim[4] = int2f(5);
        stim[5] = int2f(1);
        build_expected();
        run_frame(1'b1, -1, 1'b0);
        check("tie_value", first_out, int2f(5));
`ifdef POOL_ARGMAX_EN
        check("tie_argmax", first_arg, 2'd1);
`endif

        use_dut(1'b1);
        fill_random();
        build_expected();
        run_frame(1'b1, -1, 1'b0);
        check("full_outs", n_outs, cur_k * (cur_h / 2) * (cur_w / 2));

        fill_random();
        build_expected();
        run_frame(1'b1, 3 * cur_h * cur_w + 100, 1'b0);

        fill_random();
        build_expected();
        run_frame(1'b1, -1, 1'b0);
        check("after_abort_outs", n_outs, cur_k * (cur_h / 2) * (cur_w / 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
